// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the load/store path: width codes, byte strobes,
// LSU state encoding and memory-op classification.
package load_store_unit_pkg;

    localparam logic [3:0] MEM_WIDTH_WORD = 4'b0000;
    localparam logic [3:0] MEM_WIDTH_HALF = 4'b0101;
    localparam logic [3:0] MEM_WIDTH_BYTE = 4'b1010;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_R
    } lsu_state_e;

    typedef enum logic [1:0] {
        MEM_OP_NONE,
        MEM_OP_LOAD,
        MEM_OP_STORE,
        MEM_OP_BAD
    } mem_op_e;

    // Bad width codes and misalignment only matter for real accesses; a request
    // with neither read nor write is a harmless no-op.
    function automatic mem_op_e classify_op(input logic       rd,
                                            input logic       wr,
                                            input logic [3:0] width,
                                            input logic [1:0] offset);
        mem_op_e op;
        if (rd && wr) begin
            op = MEM_OP_BAD;
        end else if (!rd && !wr) begin
            op = MEM_OP_NONE;
        end else begin
            op = rd ? MEM_OP_LOAD : MEM_OP_STORE;
            case (width)
                MEM_WIDTH_WORD: if (offset != 2'b00) op = MEM_OP_BAD;
                MEM_WIDTH_HALF: if (offset[0]) op = MEM_OP_BAD;
                MEM_WIDTH_BYTE: ;
                default:        op = MEM_OP_BAD;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/half/word from a returned bus word and extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  width,
    input  logic        zero_extend,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (width)
            MEM_WIDTH_BYTE: result = {{24{~zero_extend & byte_sel[7]}}, byte_sel};
            MEM_WIDTH_HALF: result = {{16{~zero_extend & half_sel[15]}}, half_sel};
            default:        result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-bus access, registered bus and
// writeback outputs, rejection of misaligned or malformed requests.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   LSU_IDLE   | ready for a request; only state where req_ready_out = 1
//   LSU_REQ    | bus_valid_out held with stable address/strobes/data
//   LSU_WAIT_R | load address taken, waiting for bus_rvalid_in
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [3:0]        mem_width_in,
    input  logic              mem_zero_extend_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    input  logic [4:0]        rd_in,
    output logic              bus_valid_out,
    input  logic              bus_ready_in,
    output logic [ADDR_W-1:0] bus_addr_out,
    output logic              bus_we_out,
    output logic [3:0]        bus_wstrb_out,
    output logic [31:0]       bus_wdata_out,
    input  logic              bus_rvalid_in,
    input  logic [31:0]       bus_rdata_in,
    output logic              wb_valid_out,
    output logic [4:0]        wb_rd_out,
    output logic [31:0]       wb_data_out,
    output logic              err_out
);

    lsu_state_e  state;
    mem_op_e     op;
    logic        is_load;
    logic [3:0]  width_q;
    logic        zext_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [3:0]  store_strb;
    logic [31:0] store_wdata;
    logic [31:0] load_result;

    assign req_ready_out = (state == LSU_IDLE);
    assign op            = classify_op(mem_read_in, mem_write_in, mem_width_in, addr_in[1:0]);

    // Narrow stores are replicated across lanes; the strobes pick the live bytes.
    always_comb begin
        store_strb  = STRB_WORD;
        store_wdata = wdata_in;
        case (mem_width_in)
            MEM_WIDTH_HALF: begin
                store_strb  = STRB_HALF << addr_in[1:0];
                store_wdata = {2{wdata_in[15:0]}};
            end
            MEM_WIDTH_BYTE: begin
                store_strb  = STRB_BYTE << addr_in[1:0];
                store_wdata = {4{wdata_in[7:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata       (bus_rdata_in),
        .offset      (off_q),
        .width       (width_q),
        .zero_extend (zext_q),
        .result      (load_result)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= LSU_IDLE;
            is_load       <= 1'b0;
            width_q       <= MEM_WIDTH_WORD;
            zext_q        <= 1'b0;
            off_q         <= 2'b00;
            rd_q          <= 5'd0;
            bus_valid_out <= 1'b0;
            bus_addr_out  <= '0;
            bus_we_out    <= 1'b0;
            bus_wstrb_out <= STRB_NONE;
            bus_wdata_out <= 32'd0;
            wb_valid_out  <= 1'b0;
            wb_rd_out     <= 5'd0;
            wb_data_out   <= 32'd0;
            err_out       <= 1'b0;
        end else begin
            err_out      <= 1'b0;
            wb_valid_out <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (req_valid_in) begin
                        case (op)
                            MEM_OP_LOAD, MEM_OP_STORE: begin
                                state         <= LSU_REQ;
                                is_load       <= (op == MEM_OP_LOAD);
                                width_q       <= mem_width_in;
                                zext_q        <= mem_zero_extend_in;
                                off_q         <= addr_in[1:0];
                                rd_q          <= rd_in;
                                bus_valid_out <= 1'b1;
                                bus_addr_out  <= {addr_in[ADDR_W-1:2], 2'b00};
                                bus_we_out    <= (op == MEM_OP_STORE);
                                bus_wstrb_out <= (op == MEM_OP_STORE) ? store_strb : STRB_NONE;
                                bus_wdata_out <= (op == MEM_OP_STORE) ? store_wdata : 32'd0;
                            end
                            MEM_OP_BAD: err_out <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                LSU_REQ: begin
                    if (bus_ready_in) begin
                        bus_valid_out <= 1'b0;
                        bus_we_out    <= 1'b0;
                        bus_wstrb_out <= STRB_NONE;
                        state         <= is_load ? LSU_WAIT_R : LSU_IDLE;
                    end
                end
                LSU_WAIT_R: begin
                    if (bus_rvalid_in) begin
                        state        <= LSU_IDLE;
                        wb_valid_out <= (rd_q != 5'd0);
                        wb_rd_out    <= rd_q;
                        wb_data_out  <= load_result;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model
// checked every cycle, plus literal expectations on key scenarios.
module tb_load_store_unit;

    localparam logic [3:0] W_WORD = 4'b0000;
    localparam logic [3:0] W_HALF = 4'b0101;
    localparam logic [3:0] W_BYTE = 4'b1010;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [3:0]  mem_width_in;
    logic        mem_zero_extend_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [4:0]  rd_in;
    logic        bus_valid_out;
    logic        bus_ready_in;
    logic [31:0] bus_addr_out;
    logic        bus_we_out;
    logic [3:0]  bus_wstrb_out;
    logic [31:0] bus_wdata_out;
    logic        bus_rvalid_in;
    logic [31:0] bus_rdata_in;
    logic        wb_valid_out;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out;
    logic        err_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .req_valid_in       (req_valid_in),
        .req_ready_out      (req_ready_out),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .mem_width_in       (mem_width_in),
        .mem_zero_extend_in (mem_zero_extend_in),
        .addr_in            (addr_in),
        .wdata_in           (wdata_in),
        .rd_in              (rd_in),
        .bus_valid_out      (bus_valid_out),
        .bus_ready_in       (bus_ready_in),
        .bus_addr_out       (bus_addr_out),
        .bus_we_out         (bus_we_out),
        .bus_wstrb_out      (bus_wstrb_out),
        .bus_wdata_out      (bus_wdata_out),
        .bus_rvalid_in      (bus_rvalid_in),
        .bus_rdata_in       (bus_rdata_in),
        .wb_valid_out       (wb_valid_out),
        .wb_rd_out          (wb_rd_out),
        .wb_data_out        (wb_data_out),
        .err_out            (err_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [3:0] w);
        if (w == W_WORD) return 4;
        if (w == W_HALF) return 2;
        if (w == W_BYTE) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int size,
                                               input int off, input logic z);
        logic [31:0] v;
        logic [31:0] mask;
        if (size == 4) return rdata;
        mask = (32'h1 << (8 * size)) - 32'h1;
        v    = (rdata >> (8 * off)) & mask;
        if (!z && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model: what must be pending after each clock edge.
    logic        m_busy, m_bus_act, m_is_load, m_wait_r, m_z;
    logic [31:0] m_addr, m_wdata, m_wb_data;
    logic [3:0]  m_strb;
    logic [4:0]  m_rd, m_wb_rd;
    logic        m_wb, m_err;
    int          m_size, m_off;

    task automatic model_clear();
        m_busy = 0; m_bus_act = 0; m_is_load = 0; m_wait_r = 0; m_z = 0;
        m_addr = 0; m_wdata = 0; m_strb = 0; m_rd = 0; m_wb_rd = 0; m_wb_data = 0;
        m_wb = 0; m_err = 0; m_size = 0; m_off = 0;
    endtask

    task automatic model_edge();
        logic was_busy;
        logic nwb, nerr;
        int   sz, off;
        was_busy = m_busy;
        nwb = 0;
        nerr = 0;
        if (m_wait_r && bus_rvalid_in) begin
            m_wait_r  = 0;
            m_busy    = 0;
            nwb       = (m_rd != 0);
            m_wb_rd   = m_rd;
            m_wb_data = model_load(bus_rdata_in, m_size, m_off, m_z);
        end
        if (m_bus_act && bus_ready_in) begin
            m_bus_act = 0;
            if (m_is_load) m_wait_r = 1;
            else           m_busy = 0;
        end else if (!was_busy && req_valid_in) begin
            sz  = size_of(mem_width_in);
            off = int'(addr_in[1:0]);
            if (mem_read_in && mem_write_in) nerr = 1;
            else if (mem_read_in || mem_write_in) begin
                if (sz == 0 || (off % sz) != 0) nerr = 1;
                else begin
                    m_busy    = 1;
                    m_bus_act = 1;
                    m_is_load = mem_read_in;
                    m_size    = sz;
                    m_off     = off;
                    m_z       = mem_zero_extend_in;
                    m_rd      = rd_in;
                    m_addr    = addr_in & ~32'h3;
                    if (mem_read_in) begin
                        m_strb  = 4'b0000;
                        m_wdata = 0;
                    end else begin
                        m_strb = 4'(((1 << sz) - 1) << off);
                        if (sz == 1)      m_wdata = {24'd0, wdata_in[7:0]} * 32'h0101_0101;
                        else if (sz == 2) m_wdata = {16'd0, wdata_in[15:0]} * 32'h0001_0001;
                        else              m_wdata = wdata_in;
                    end
                end
            end
        end
        m_wb  = nwb;
        m_err = nerr;
    endtask

    task automatic model_compare();
        if (!rst_n_in) begin
            chk("rst_ready", req_ready_out, 1);
            chk("rst_bus_valid", bus_valid_out, 0);
            chk("rst_bus_we", bus_we_out, 0);
            chk("rst_bus_wstrb", bus_wstrb_out, 0);
            chk("rst_bus_addr", bus_addr_out, 0);
            chk("rst_bus_wdata", bus_wdata_out, 0);
            chk("rst_wb_valid", wb_valid_out, 0);
            chk("rst_wb_data", wb_data_out, 0);
            chk("rst_err", err_out, 0);
            model_clear();
        end else begin
            chk("ready", req_ready_out, !m_busy);
            chk("bus_valid", bus_valid_out, m_bus_act);
            if (m_bus_act) begin
                chk("bus_addr", bus_addr_out, m_addr);
                chk("bus_we", bus_we_out, !m_is_load);
                chk("bus_wstrb", bus_wstrb_out, m_strb);
                if (!m_is_load) chk("bus_wdata", bus_wdata_out, m_wdata);
            end
            chk("wb_valid", wb_valid_out, m_wb);
            if (m_wb) begin
                chk("wb_rd", wb_rd_out, m_wb_rd);
                chk("wb_data", wb_data_out, m_wb_data);
            end
            chk("err", err_out, m_err);
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk_in);
            if (rst_n_in) model_edge();
            @(negedge clk_in);
            model_compare();
        end
    end

    task automatic drive_req(input logic rd, input logic wr, input logic [3:0] w, input logic z,
                             input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdst);
        req_valid_in       = 1;
        mem_read_in        = rd;
        mem_write_in       = wr;
        mem_width_in       = w;
        mem_zero_extend_in = z;
        addr_in            = a;
        wdata_in           = wd;
        rd_in              = rdst;
    endtask

    // Legal access: bus_ready held low for ready_wait cycles, rvalid r_wait cycles later.
    task automatic xfer(input logic rd, input logic wr, input logic [3:0] w, input logic z,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdst,
                        input logic [31:0] rdat, input int ready_wait, input int r_wait,
                        output logic wbv, output logic [31:0] wbd, output logic [31:0] c_addr,
                        output logic [3:0] c_strb, output logic [31:0] c_wdata,
                        output logic c_we);
        @(negedge clk_in);
        drive_req(rd, wr, w, z, a, wd, rdst);
        @(negedge clk_in);
        req_valid_in = 0;
        chk("bus_valid_latency", bus_valid_out, 1);
        c_addr  = bus_addr_out;
        c_strb  = bus_wstrb_out;
        c_wdata = bus_wdata_out;
        c_we    = bus_we_out;
        repeat (ready_wait) @(negedge clk_in);
        bus_ready_in = 1;
        @(negedge clk_in);
        bus_ready_in = 0;
        if (rd) begin
            repeat (r_wait) @(negedge clk_in);
            bus_rvalid_in = 1;
            bus_rdata_in  = rdat;
            @(negedge clk_in);
            bus_rvalid_in = 0;
        end
        wbv = wb_valid_out;
        wbd = wb_data_out;
    endtask

    task automatic reject(input string name, input logic rd, input logic wr,
                          input logic [3:0] w, input logic [31:0] a);
        @(negedge clk_in);
        drive_req(rd, wr, w, 1'b0, a, 32'h0, 5'd1);
        @(negedge clk_in);
        req_valid_in = 0;
        chk({name, "_err"}, err_out, 1);
        chk({name, "_no_bus"}, bus_valid_out, 0);
        chk({name, "_ready"}, req_ready_out, 1);
    endtask

    logic        wbv, c_we;
    logic [31:0] wbd, c_addr, c_wdata;
    logic [3:0]  c_strb;

    initial begin
        rst_n_in = 1;
        req_valid_in = 0; mem_read_in = 0; mem_write_in = 0; mem_width_in = W_WORD;
        mem_zero_extend_in = 0; addr_in = 0; wdata_in = 0; rd_in = 0;
        bus_ready_in = 0; bus_rvalid_in = 0; bus_rdata_in = 0;
        #1 rst_n_in = 0;
        repeat (3) @(negedge clk_in);
        #2 rst_n_in = 1;
        @(negedge clk_in);
        chk("ready_after_reset", req_ready_out, 1);

        xfer(1, 0, W_BYTE, 0, 32'h103, 0, 5'd5, 32'h80FF_FF00, 0, 0, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("lb_wb_valid", wbv, 1);
        chk("lb_data", wbd, 32'hFFFF_FF80);
        chk("lb_addr", c_addr, 32'h100);

        xfer(1, 0, W_BYTE, 1, 32'h103, 0, 5'd6, 32'h80FF_FF00, 0, 1, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("lbu_data", wbd, 32'h0000_0080);

        xfer(0, 1, W_HALF, 0, 32'h202, 32'h1234_ABCD, 5'd0, 0, 0, 0, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("sh_addr", c_addr, 32'h200);
        chk("sh_strb", c_strb, 4'b1100);
        chk("sh_wdata", c_wdata, 32'hABCD_ABCD);
        chk("sh_we", c_we, 1);
        chk("sh_no_wb", wbv, 0);

        reject("lw_misaligned", 1, 0, W_WORD, 32'h101);
        reject("sh_odd", 0, 1, W_HALF, 32'h203);
        reject("bad_width", 1, 0, 4'b0011, 32'h100);
        reject("rd_and_wr", 1, 1, W_BYTE, 32'h100);

        @(negedge clk_in);
        drive_req(0, 0, 4'b0011, 0, 32'h101, 0, 5'd2);
        @(negedge clk_in);
        req_valid_in = 0;
        chk("noop_err", err_out, 0);
        chk("noop_ready", req_ready_out, 1);

        xfer(0, 1, W_WORD, 0, 32'h300, 32'hCAFE_F00D, 5'd0, 0, 5, 0, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("sw_strb", c_strb, 4'b1111);
        chk("sw_wdata", c_wdata, 32'hCAFE_F00D);

        xfer(1, 0, W_HALF, 0, 32'h106, 0, 5'd7, 32'h8001_7FFF, 2, 0, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("lh_data", wbd, 32'hFFFF_8001);
        xfer(1, 0, W_HALF, 1, 32'h104, 0, 5'd8, 32'h8001_7FFF, 0, 0, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("lhu_data", wbd, 32'h0000_7FFF);
        xfer(1, 0, W_WORD, 1, 32'h108, 0, 5'd9, 32'h1234_5678, 1, 3, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("lw_data", wbd, 32'h1234_5678);
        xfer(0, 1, W_BYTE, 0, 32'h101, 32'h0000_0055, 5'd0, 0, 0, 0, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("sb_strb", c_strb, 4'b0010);
        chk("sb_wdata", c_wdata, 32'h5555_5555);

        xfer(1, 0, W_WORD, 0, 32'h104, 0, 5'd0, 32'hDEAD_BEEF, 0, 0, wbv, wbd, c_addr, c_strb, c_wdata, c_we);
        chk("rd0_read_we", c_we, 0);
        chk("rd0_no_wb", wbv, 0);

        @(negedge clk_in);
        drive_req(1, 0, W_WORD, 0, 32'h100, 0, 5'd3);
        @(negedge clk_in);
        req_valid_in = 0;
        bus_ready_in = 1;
        @(negedge clk_in);
        bus_ready_in = 0;
        chk("wait_r_not_ready", req_ready_out, 0);
        #2 rst_n_in = 0;
        @(negedge clk_in);
        #2 rst_n_in = 1;
        @(negedge clk_in);
        bus_rvalid_in = 1;
        bus_rdata_in  = 32'h7777_7777;
        @(negedge clk_in);
        bus_rvalid_in = 0;
        chk("late_rvalid_no_wb", wb_valid_out, 0);
        chk("late_rvalid_idle", req_ready_out, 1);

        repeat (3) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of request and bus address.
REQ-002 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid_in  input  1  memory request from execute stage.
REQ-005 req_ready_out  output  1  unit can accept a request.
REQ-006 mem_read_in / mem_write_in  input  1 each  load / store from decoder.
REQ-007 mem_width_in  input  4  0000 word, 0101 half, 1010 byte.
REQ-008 mem_zero_extend_in  input  1  1 zero-extend load, 0 sign-extend.
REQ-009 addr_in  input  ADDR_W  effective byte address from ALU.
REQ-010 wdata_in  input  32  rs2 store data.
REQ-011 rd_in  input  5  load destination register.
REQ-012 bus_valid_out / bus_ready_in  output / input  1 each  data-bus request handshake.
REQ-013 bus_addr_out  output  ADDR_W  word-aligned address; bits [1:0] always 0.
REQ-014 bus_we_out, bus_wstrb_out, bus_wdata_out  output  1, 4, 32  write enable, byte strobes, lane-replicated data.
REQ-015 bus_rvalid_in / bus_rdata_in  input  1 / 32  read data return.
REQ-016 wb_valid_out, wb_rd_out, wb_data_out  output  1, 5, 32  load result to writeback.
REQ-017 err_out  output  1  one-cycle pulse on rejected request.

Function
REQ-018 FSM states IDLE, REQ, WAIT_R; req_ready_out SHALL be 1 only in IDLE.
REQ-019 Request accepted when req_valid_in && req_ready_out; operands registered at acceptance.
REQ-020 Accepted legal load/store: IDLE->REQ; bus_valid_out asserted from the next cycle, address/strobes/data held stable until bus_ready_in.
REQ-021 REQ with bus_ready_in: store -> IDLE; load -> WAIT_R.
REQ-022 WAIT_R SHALL sample bus_rvalid_in only in that state (earliest one cycle after bus_ready_in); on rvalid -> IDLE, wb_valid_out=1 for exactly the next cycle with the extracted data.
REQ-023 Load extraction: offset = addr[1:0]; byte = rdata[8*offset+7:8*offset]; half = rdata[16*addr[1]+15:16*addr[1]]; extended per mem_zero_extend_in; word ignores extend bit.
REQ-024 Store: byte -> wdata {4{wdata[7:0]}}, wstrb 0001<<offset; half -> {2{wdata[15:0]}}, wstrb 0011<<offset; word -> wdata, wstrb 1111; loads drive wstrb 0000, we 0.
REQ-025 Rejected (stay IDLE, no bus cycle, err_out pulse next cycle): half with addr[0]=1; word with addr[1:0]!=0; width code outside the three legal values; read and write both 1.
REQ-026 Accepted request with neither read nor write: no-op, stays IDLE, no error.
REQ-027 Load to rd_in=0 SHALL perform the bus access but suppress wb_valid_out.
REQ-028 Minimum latency: accept N, bus_valid N+1, store complete N+1 if bus_ready; load wb_valid at rvalid-cycle+1.
REQ-029 New request SHALL NOT be accepted in the cycle wb_valid_out is high only if FSM not in IDLE; back-to-back acceptance allowed once IDLE.

Reset
REQ-030 rst_n_in low SHALL force IDLE immediately; bus_valid_out, bus_we_out, wb_valid_out, err_out, bus_wstrb_out =0; data/address outputs 0.
REQ-031 Reset mid-transaction abandons it; late bus_rvalid_in after reset SHALL be ignored (FSM in IDLE).
REQ-032 req_ready_out SHALL be 1 on the first cycle after rst_n_in deasserts.

Structure
REQ-033 Width codes (MEM_WIDTH_*), FSM state enum and strobe constants SHALL live in the shared core package alongside opcode/type definitions.
REQ-034 One combinational sub-module load_align (rdata, offset, width, zero_extend -> 32-bit result), reused by the bench as reference.

Verification
REQ-035 LB addr 0x103, rdata 0x80FF_FF00 -> wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-036 SH addr 0x202, wdata 0x1234_ABCD -> bus_addr 0x200, wstrb 1100, wdata 0xABCD_ABCD, no wb_valid.
REQ-037 LW addr 0x101 -> err_out pulse, bus_valid never asserted, ready stays 1.
REQ-038 SW with bus_ready held low 5 cycles -> bus outputs stable all 5 cycles, ready low until completion.
REQ-039 LW issued, rst_n_in low in WAIT_R, rvalid arrives after release -> no wb_valid, FSM IDLE.
REQ-040 LW to rd 0, rdata 0xDEAD_BEEF -> bus read performed, wb_valid stays 0.
